// File: rtl/pio_shadow_bank.sv
// pio_shadow_bank
//   Double-buffered, multi-channel output PIO behind an Avalon-MM slave.
//   Software writes per-channel shadow registers and then commits all of them
//   to the live outputs in one clock edge. The commit happens either on the
//   next edge (immediate mode) or on the next rising edge of sync_in (sync
//   mode), so related output words always change together.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   address      word address (CTRL=0, COUNT=1, shadows at 4+i, live at 4+N_CH+i)
//   chipselect   slave select; write = chipselect & ~write_n
//   write_n      active-low write strobe
//   writedata    32-bit write data
//   readdata     combinational read data, decoded from address alone
//   sync_in      asynchronous commit strobe, rising-edge sensitive
//   out_port     live outputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   commit_done  one-cycle pulse in the cycle after the live outputs load

module pio_shadow_bank #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          N_CH        = 4,
  parameter int          ADDR_WIDTH  = 4,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  input  logic                       sync_in,
  output logic [N_CH*DATA_WIDTH-1:0] out_port,
  output logic                       commit_done
);

  localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VALUE[DATA_WIDTH-1:0];

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    sync_mode_q, sync_mode_d;
  logic [15:0]             count_q, count_d;
  logic                    commit_done_q, commit_done_d;
  logic [2:0]              sync_q, sync_d;
  logic [DATA_WIDTH-1:0]   shadow_q [N_CH];
  logic [DATA_WIDTH-1:0]   shadow_d [N_CH];
  logic [DATA_WIDTH-1:0]   live_q   [N_CH];
  logic [DATA_WIDTH-1:0]   live_d   [N_CH];

  logic wr_en;
  logic ctrl_wr;
  logic commit_req;
  logic abort_req;
  logic sync_rise;
  logic transfer;

  assign wr_en      = chipselect & ~write_n;
  assign ctrl_wr    = wr_en && (address == '0);
  // ABORT in the same word as COMMIT cancels the commit request.
  assign commit_req = ctrl_wr & writedata[0] & ~writedata[3];
  assign abort_req  = ctrl_wr & writedata[3];
  // sync_q[0..1] are the synchroniser, sync_q[2] is the edge-detect history.
  assign sync_rise  = sync_q[1] & ~sync_q[2];
  // Mode is the pre-edge value, so a SYNC_MODE write only affects later edges.
  assign transfer   = (state_q == ARMED) && (!sync_mode_q || sync_rise);

  always_comb begin
    sync_d        = {sync_q[1:0], sync_in};
    sync_mode_d   = sync_mode_q;
    count_d       = count_q;
    commit_done_d = transfer;
    state_d       = state_q;

    if (ctrl_wr) begin
      sync_mode_d = writedata[1];
    end
    if (transfer) begin
      count_d = count_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (commit_req) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // A COMMIT landing on the transfer edge re-arms for another transfer.
        if (abort_req) begin
          state_d = IDLE;
        end else if (transfer && !commit_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      live_d[i]   = live_q[i];
      // Live takes the pre-edge shadow; a same-edge shadow write stays in the shadow.
      if (transfer) begin
        live_d[i] = shadow_q[i];
      end
      if (wr_en && (address == ADDR_WIDTH'(4 + i))) begin
        shadow_d[i] = writedata[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sync_mode_q   <= 1'b0;
      count_q       <= '0;
      commit_done_q <= 1'b0;
      sync_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= RST_VAL;
        live_q[i]   <= RST_VAL;
      end
    end else begin
      state_q       <= state_d;
      sync_mode_q   <= sync_mode_d;
      count_q       <= count_d;
      commit_done_q <= commit_done_d;
      sync_q        <= sync_d;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        live_q[i]   <= live_d[i];
      end
    end
  end

  // Read decode ignores chipselect so readdata settles purely from address.
  always_comb begin
    readdata = '0;
    if (address == '0) begin
      readdata[2:0] = {(state_q == ARMED), sync_mode_q, 1'b0};
    end else if (address == ADDR_WIDTH'(1)) begin
      readdata[15:0] = count_q;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (address == ADDR_WIDTH'(4 + i)) begin
        readdata = 32'(shadow_q[i]);
      end
      if (address == ADDR_WIDTH'(4 + N_CH + i)) begin
        readdata = 32'(live_q[i]);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign out_port[g*DATA_WIDTH +: DATA_WIDTH] = live_q[g];
  end

  assign commit_done = commit_done_q;

endmodule
